// File: rtl/mux_select_sequencer_if.sv
// Token stream bundle between mux_select_sequencer and fifo_mux2.
//   select        token value: 0 = stream a, 1 = stream b
//   select_valid  token valid (driven by the sequencer)
//   select_ready  downstream accepts the token (driven by the consumer)
//   layer         layer index of the current token
//   elem          element index of the current token within its layer
//   last_elem     current token is the last element of its layer
interface mux_select_sequencer_if #(
  parameter int LAYER_W = 4,
  parameter int ELEM_W  = 4
);
  logic               select;
  logic               select_valid;
  logic               select_ready;
  logic [LAYER_W-1:0] layer;
  logic [ELEM_W-1:0]  elem;
  logic               last_elem;

  modport master (
    output select, select_valid, layer, elem, last_elem,
    input  select_ready
  );

  modport slave (
    input  select, select_valid, layer, elem, last_elem,
    output select_ready
  );
endinterface

// File: rtl/mux_select_sequencer.sv
// mux_select_sequencer
// Generates the select token stream for fifo_mux2 in the layer-multiplexed
// datapath. One pass issues VECTOR_LEN tokens with select=0 (layer 0, the
// external input) followed by (NUM_LAYERS-1)*VECTOR_LEN tokens with select=1
// (fed-back layer outputs).
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request a new pass (only honoured while idle)
//   abort  in   cancel the pass in progress
//   busy   out  a pass is being issued
//   done   out  one-cycle pulse after the final token is accepted
//   tok    master side of the token stream (select/valid/ready/layer/elem/last_elem)
module mux_select_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int VECTOR_LEN = 4,
  parameter int LAYER_W    = 4,
  parameter int ELEM_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  mux_select_sequencer_if.master tok
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [ELEM_W-1:0]  ELEM_LAST  = ELEM_W'(VECTOR_LEN - 1);
  // With one-element layers every token closes its layer.
  localparam logic               FIRST_LAST = (VECTOR_LEN == 1);

  state_t             state_q, state_d;
  logic               select_q, select_d;
  logic               valid_q, valid_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [ELEM_W-1:0]  elem_q, elem_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ELEM_W-1:0]  elem_inc;

  assign elem_inc = elem_q + ELEM_W'(1);

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      select_q <= 1'b0;
      valid_q  <= 1'b0;
      layer_q  <= '0;
      elem_q   <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      valid_q  <= valid_d;
      layer_q  <= layer_d;
      elem_q   <= elem_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic. Token fields hold by default, which
  // gives the stall behaviour for free when select_ready is low. Outside a
  // pass the token fields are parked at zero.
  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    valid_d  = valid_q;
    layer_d  = layer_q;
    elem_d   = elem_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = ISSUE;
          select_d = 1'b0;
          valid_d  = 1'b1;
          layer_d  = '0;
          elem_d   = '0;
          last_d   = FIRST_LAST;
          busy_d   = 1'b1;
        end
      end

      ISSUE: begin
        if (abort) begin
          state_d  = IDLE;
          select_d = 1'b0;
          valid_d  = 1'b0;
          layer_d  = '0;
          elem_d   = '0;
          last_d   = 1'b0;
          busy_d   = 1'b0;
        end else if (tok.select_ready) begin
          if (elem_q != ELEM_LAST) begin
            elem_d = elem_inc;
            last_d = (elem_inc == ELEM_LAST);
          end else if (layer_q != LAYER_LAST) begin
            // Every layer after the first is fed back, so select goes high.
            layer_d  = layer_q + LAYER_W'(1);
            elem_d   = '0;
            select_d = 1'b1;
            last_d   = FIRST_LAST;
          end else begin
            state_d  = DONE;
            select_d = 1'b0;
            valid_d  = 1'b0;
            layer_d  = '0;
            elem_d   = '0;
            last_d   = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tok.select       = select_q;
  assign tok.select_valid = valid_q;
  assign tok.layer        = layer_q;
  assign tok.elem         = elem_q;
  assign tok.last_elem    = last_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb_mux_select_sequencer
// Self-checking bench for mux_select_sequencer. A token-counter model tracks
// the pass (idle / issuing token k / done pulse) and a compare process checks
// every DUT output against it on each falling edge. Directed sequences with
// literal expectations pin the model, followed by randomized stimulus. A
// second instance covers the NUM_LAYERS=1, VECTOR_LEN=1 corner.
module tb_mux_select_sequencer;

  localparam int NL = 3;
  localparam int VL = 4;
  localparam int NTOK = NL * VL;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  logic ready;
  logic busy;
  logic done;

  logic c_start;
  logic c_abort;
  logic c_ready;
  logic c_busy;
  logic c_done;

  int n_checks = 0;
  int n_fail   = 0;

  mux_select_sequencer_if #(.LAYER_W(4), .ELEM_W(4)) tok ();
  mux_select_sequencer_if #(.LAYER_W(4), .ELEM_W(4)) tok_c ();

  assign tok.select_ready   = ready;
  assign tok_c.select_ready = c_ready;

  mux_select_sequencer #(
    .NUM_LAYERS(NL), .VECTOR_LEN(VL), .LAYER_W(4), .ELEM_W(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .tok(tok)
  );

  mux_select_sequencer #(
    .NUM_LAYERS(1), .VECTOR_LEN(1), .LAYER_W(4), .ELEM_W(4)
  ) dut_corner (
    .clk(clk), .rst(rst), .start(c_start), .abort(c_abort),
    .busy(c_busy), .done(c_done), .tok(tok_c)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 issuing token m_k, 2 done pulse.
  int m_phase = 0;
  int m_k     = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_k     = 0;
    end else begin
      case (m_phase)
        0: if (start && !abort) begin m_phase = 1; m_k = 0; end
        1: begin
          if (abort) m_phase = 0;
          else if (ready) begin
            if (m_k == NTOK - 1) m_phase = 2;
            else m_k = m_k + 1;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    int e_layer;
    int e_elem;
    e_layer = (m_phase == 1) ? m_k / VL : 0;
    e_elem  = (m_phase == 1) ? m_k % VL : 0;
    checkOutput("model_valid", 32'(tok.select_valid), 32'(m_phase == 1));
    checkOutput("model_busy",  32'(busy),             32'(m_phase == 1));
    checkOutput("model_done",  32'(done),             32'(m_phase == 2));
    checkOutput("model_layer", 32'(tok.layer),        32'(e_layer));
    checkOutput("model_elem",  32'(tok.elem),         32'(e_elem));
    checkOutput("model_select", 32'(tok.select),      32'(m_phase == 1 && e_layer != 0));
    checkOutput("model_last",  32'(tok.last_elem),    32'(m_phase == 1 && e_elem == VL - 1));
  end

  // Drive inputs for one cycle, then return at the next falling edge.
  task automatic applyStimulus(input logic st, input logic ab, input logic rd, input logic rs);
    start = st;
    abort = ab;
    ready = rd;
    rst   = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [NTOK-1:0] sel_exp;
  logic [NTOK-1:0] last_exp;

  initial begin
    int xfers;
    int dones;
    logic was_last;
    logic [9:0] snap;
    logic [15:0] valid_seen;

    sel_exp  = 12'b1111_1111_0000;
    last_exp = 12'b1000_1000_1000;
    c_start  = 1'b0;
    c_abort  = 1'b0;
    c_ready  = 1'b1;

    // Reset with start asserted: nothing may be issued.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("reset_valid", 32'(tok.select_valid), 0);
    checkOutput("reset_busy",  32'(busy), 0);
    checkOutput("reset_done",  32'(done), 0);
    checkOutput("reset_layer", 32'(tok.layer), 0);
    checkOutput("reset_last",  32'(tok.last_elem), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Full pass with ready held high: 12 back-to-back tokens, then done.
    $display("[TB] full pass, ready=1");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < NTOK; i++) begin
      checkOutput("pass_valid",  32'(tok.select_valid), 1);
      checkOutput("pass_select", 32'(tok.select), 32'(sel_exp[i]));
      checkOutput("pass_last",   32'(tok.last_elem), 32'(last_exp[i]));
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("pass_done",       32'(done), 1);
    checkOutput("pass_done_valid", 32'(tok.select_valid), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pass_done_pulse", 32'(done), 0);

    // Backpressure: ready alternates 1,0.
    $display("[TB] backpressure pass");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    xfers = 0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      logic rd;
      rd = (c % 2 == 0);
      was_last = 1'b0;
      snap = {tok.select, tok.last_elem, tok.layer, tok.elem};
      if (tok.select_valid && rd) begin
        if (xfers < NTOK) checkOutput("bp_select", 32'(tok.select), 32'(sel_exp[xfers]));
        xfers++;
        was_last = (xfers == NTOK);
      end
      if (tok.select_valid && !rd) begin
        applyStimulus(1'b0, 1'b0, rd, 1'b0);
        checkOutput("bp_stall_hold", 32'({tok.select, tok.last_elem, tok.layer, tok.elem}), 32'(snap));
        checkOutput("bp_stall_valid", 32'(tok.select_valid), 1);
      end else begin
        applyStimulus(1'b0, 1'b0, rd, 1'b0);
        if (was_last) checkOutput("bp_done_after_last", 32'(done), 1);
      end
      if (done) dones++;
    end
    checkOutput("bp_transfers", 32'(xfers), 12);
    checkOutput("bp_done_count", 32'(dones), 1);

    // start held high: pass, done, one idle cycle, then a second pass.
    $display("[TB] start held high");
    for (int s = 1; s <= 15; s++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      valid_seen[s] = tok.select_valid;
      if (s == 13) checkOutput("hold_done", 32'(done), 1);
    end
    checkOutput("hold_valid_pattern", 32'(valid_seen[15:1]), 32'(15'b100_1111_1111_1111));
    checkOutput("hold_restart_layer", 32'(tok.layer), 0);
    checkOutput("hold_restart_elem",  32'(tok.elem), 0);
    for (int s = 0; s < 12; s++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Abort after six transfers, then restart.
    $display("[TB] abort mid-pass");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    for (int s = 0; s < 6; s++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("abort_pre_layer", 32'(tok.layer), 1);
    checkOutput("abort_pre_elem",  32'(tok.elem), 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("abort_valid", 32'(tok.select_valid), 0);
    checkOutput("abort_done",  32'(done), 0);
    dones = 0;
    for (int s = 0; s < 6; s++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      if (done) dones++;
    end
    checkOutput("abort_no_done", 32'(dones), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("abort_restart_valid",  32'(tok.select_valid), 1);
    checkOutput("abort_restart_layer",  32'(tok.layer), 0);
    checkOutput("abort_restart_select", 32'(tok.select), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    // start together with abort while idle: stays idle.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("start_abort_idle", 32'(tok.select_valid), 0);

    // Reset during a stall mid-pass.
    $display("[TB] reset during stall");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_stall_valid", 32'(tok.select_valid), 0);
    checkOutput("rst_stall_elem",  32'(tok.elem), 0);
    checkOutput("rst_stall_busy",  32'(busy), 0);

    // Randomized stimulus against the model.
    $display("[TB] random stimulus");
    for (int r = 0; r < 2000; r++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // NUM_LAYERS=1, VECTOR_LEN=1: single token, then done.
    $display("[TB] single-token corner");
    c_start = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    c_start = 1'b0;
    checkOutput("corner_valid",  32'(tok_c.select_valid), 1);
    checkOutput("corner_select", 32'(tok_c.select), 0);
    checkOutput("corner_last",   32'(tok_c.last_elem), 1);
    checkOutput("corner_busy",   32'(c_busy), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("corner_done",       32'(c_done), 1);
    checkOutput("corner_done_valid", 32'(tok_c.select_valid), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("corner_done_pulse", 32'(c_done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
